// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch / sequencing unit:
//   - fetch_state_t : run-control state encoding (IDLE, RUN, HALT)
//   - default field widths for PC, machine code, opcode and LUT index
//   - HALT_CODE     : machine-code word that ends a program (all ones)
//   - BR_TARGETS    : constant branch-target table, absolute PC addresses
// Ports: none (package).
// ---------------------------------------------------------------------------
package fetch_pkg;

   localparam int PC_W_DEF  = 10;
   localparam int IW_DEF    = 9;
   localparam int OPW_DEF   = 3;
   localparam int LUT_W_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_t;

   localparam logic [IW_DEF-1:0] HALT_CODE = '1;

   // Branch targets are absolute addresses. The assembler-side checker reads
   // the same table, so entries must only change together with the assembler.
   localparam logic [PC_W_DEF-1:0] BR_TARGETS [2**LUT_W_DEF] = '{
      10'd0,   10'd16,  10'd40,  10'd64,
      10'd100, 10'd200, 10'd300, 10'd400,
      10'd500, 10'd600, 10'd700, 10'd800,
      10'd900, 10'd1000, 10'd1020, 10'd1023
   };

endpackage

// File: rtl/branch_lut.sv
// ---------------------------------------------------------------------------
// branch_lut
// Combinational lookup of a branch target address from the low machine-code
// bits. Kept as its own module so the assembler-side checker can instantiate
// exactly the same table.
// Ports:
//   i_idx    in   LUT_W_DEF  branch-target table index
//   o_target out  PC_W_DEF   absolute target address
// ---------------------------------------------------------------------------
module branch_lut
   import fetch_pkg::*;
(
   input  logic [LUT_W_DEF-1:0] i_idx,
   output logic [PC_W_DEF-1:0]  o_target
);

   assign o_target = BR_TARGETS[i_idx];

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction fetch and sequencing unit. Owns the program counter, the
// start/done run handshake with the harness and branch redirection. Issues
// one instruction per clock unless stalled.
// Ports:
//   clk          in   1      clock, all state on rising edge
//   reset        in   1      synchronous, active-high
//   start        in   1      run request (acted on in IDLE and HALT only)
//   mach_code    in   IW     ROM data at prog_ctr (combinational read)
//   branch       in   1      decoder Branch for the current instruction
//   taken        in   1      ALU condition flag
//   stall        in   1      freeze request from the datapath
//   prog_ctr     out  PC_W   registered program counter / ROM address
//   instr        out  OPW    opcode field to the decoder
//   typeselect   out  2      type field to the decoder
//   instr_valid  out  1      current instruction executes this cycle
//   done         out  1      registered, high while halted
// ---------------------------------------------------------------------------
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int IW    = IW_DEF,
   parameter int OPW   = OPW_DEF,
   parameter int LUT_W = LUT_W_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [IW-1:0]   mach_code,
   input  logic            branch,
   input  logic            taken,
   input  logic            stall,
   output logic [PC_W-1:0] prog_ctr,
   output logic [OPW-1:0]  instr,
   output logic [1:0]      typeselect,
   output logic            instr_valid,
   output logic            done
);

   fetch_state_t    r_state;
   logic [PC_W-1:0] r_pc;
   logic            r_done;

   logic            w_is_halt;
   logic            w_take;
   logic [PC_W-1:0] w_target;
   logic [PC_W-1:0] w_pc_inc;

   branch_lut u_branch_lut (
      .i_idx    (mach_code[LUT_W-1:0]),
      .o_target (w_target)
   );

   assign w_is_halt = (mach_code == HALT_CODE);
   // taken is meaningless unless the decoder flags a branch
   assign w_take    = branch && taken;
   // natural PC_W-bit wrap; rolling over from the top address is not a halt
   assign w_pc_inc  = r_pc + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_pc    <= '0;
         r_done  <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               r_pc <= '0;
               if (start) begin
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               // a stall freezes everything, including halt and branch decisions
               if (!stall) begin
                  if (w_is_halt) begin
                     r_state <= ST_HALT;
                     r_done  <= 1'b1;
                  end else if (w_take) begin
                     r_pc <= w_target;
                  end else begin
                     r_pc <= w_pc_inc;
                  end
               end
            end
            ST_HALT: begin
               if (start) begin
                  r_state <= ST_RUN;
                  r_pc    <= '0;
                  r_done  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_pc    <= '0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign prog_ctr    = r_pc;
   assign done        = r_done;

   // Field slices are ungated: opcode 000 is a legal store, so downstream
   // writes are qualified by instr_valid rather than by masking the opcode.
   assign instr       = mach_code[IW-1 -: OPW];
   assign typeselect  = mach_code[IW-OPW-1 -: 2];
   assign instr_valid = (r_state == ST_RUN) && !stall && !w_is_halt;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [8:0] mach_code;
   logic       branch;
   logic       taken;
   logic       stall;
   logic [9:0] prog_ctr;
   logic [2:0] instr;
   logic [1:0] typeselect;
   logic       instr_valid;
   logic       done;

   logic [8:0] rom    [1024];
   logic       br_mem [1024];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign mach_code = rom[prog_ctr];
   assign branch    = br_mem[prog_ctr];

   instr_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .mach_code   (mach_code),
      .branch      (branch),
      .taken       (taken),
      .stall       (stall),
      .prog_ctr    (prog_ctr),
      .instr       (instr),
      .typeselect  (typeselect),
      .instr_valid (instr_valid),
      .done        (done)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Non-halt, non-branch filler word: opcode i%7 never reaches 3'b111.
   function automatic logic [8:0] op(input int i);
      logic [2:0] o;
      logic [1:0] t;
      logic [3:0] l;
      o = 3'(i % 7);
      t = 2'(i);
      l = 4'(i);
      return {o, t, l};
   endfunction

   task automatic load_linear();
      for (int i = 0; i < 1024; i++) begin
         rom[i]    = op(i);
         br_mem[i] = 1'b0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      stall = 1'b0;
      taken = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         vcount;
      logic       done_seen;
      logic [8:0] w;

      // ---------------- reset state, 5 ops + HALT ----------------
      load_linear();
      rom[5] = 9'h1FF;
      do_reset();
      w = rom[0];
      check_eq("rst_pc", prog_ctr, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_valid", instr_valid, 0);
      check_eq("rst_instr", instr, w[8:6]);
      check_eq("rst_type", typeselect, w[5:4]);
      tick();
      check_eq("idle_pc", prog_ctr, 0);
      check_eq("idle_valid", instr_valid, 0);

      pulse_start();
      vcount = 0;
      for (int c = 0; c < 6; c++) begin
         check_eq("seq_pc", prog_ctr, c);
         check_eq("seq_done", done, 0);
         vcount += int'(instr_valid);
         tick();
      end
      check_eq("halt_done", done, 1);
      check_eq("halt_pc", prog_ctr, 5);
      check_eq("halt_valid", instr_valid, 0);
      check_eq("valid_cnt", vcount, 5);

      // ---------------- restart from HALT, start ignored in RUN ----------------
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("rs_pc", prog_ctr, 0);
      check_eq("rs_done", done, 0);
      check_eq("rs_valid", instr_valid, 1);
      vcount = 0;
      for (int c = 0; c < 6; c++) begin
         check_eq("rs_seq_pc", prog_ctr, c);
         w = rom[c];
         check_eq("rs_instr", instr, w[8:6]);
         vcount += int'(instr_valid);
         if (c == 2) start = 1'b1;
         tick();
         start = 1'b0;
      end
      check_eq("rs_halt_done", done, 1);
      check_eq("rs_valid_cnt", vcount, 5);

      // ---------------- branch taken / not taken ----------------
      load_linear();
      rom[3]    = 9'b100_10_0010;   // index 2 -> target 40
      br_mem[3] = 1'b1;
      rom[40]   = 9'h1FF;
      rom[4]    = 9'h1FF;
      do_reset();
      taken = 1'b1;
      pulse_start();
      repeat (3) tick();
      check_eq("br_at3", prog_ctr, 3);
      check_eq("br_valid", instr_valid, 1);
      tick();
      check_eq("br_taken_pc", prog_ctr, 40);
      tick();
      check_eq("br_taken_done", done, 1);
      taken = 1'b0;
      pulse_start();
      repeat (3) tick();
      check_eq("nb_at3", prog_ctr, 3);
      tick();
      check_eq("nb_pc", prog_ctr, 4);
      check_eq("nb_halt_valid", instr_valid, 0);
      tick();
      check_eq("nb_done", done, 1);

      // ---------------- stall over taken branch and over HALT ----------------
      load_linear();
      rom[7]    = 9'b101_11_0101;   // index 5 -> target 200
      br_mem[7] = 1'b1;
      rom[200]  = 9'h1FF;
      do_reset();
      taken = 1'b1;
      pulse_start();
      repeat (7) tick();
      check_eq("st_at7", prog_ctr, 7);
      stall = 1'b1;
      #1;
      check_eq("st_valid_comb", instr_valid, 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check_eq("st_pc_hold", prog_ctr, 7);
         check_eq("st_valid", instr_valid, 0);
      end
      stall = 1'b0;
      #1;
      check_eq("st_release_valid", instr_valid, 1);
      tick();
      check_eq("st_branch_pc", prog_ctr, 200);
      check_eq("st_halt_valid", instr_valid, 0);
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check_eq("sh_pc_hold", prog_ctr, 200);
         check_eq("sh_done", done, 0);
      end
      stall = 1'b0;
      tick();
      check_eq("sh_done_after", done, 1);
      check_eq("sh_pc_after", prog_ctr, 200);

      // ---------------- PC wrap ----------------
      load_linear();
      do_reset();
      pulse_start();
      done_seen = 1'b0;
      for (int c = 0; c < 1023; c++) begin
         tick();
         done_seen = done_seen | done;
      end
      check_eq("wrap_top", prog_ctr, 1023);
      tick();
      done_seen = done_seen | done;
      check_eq("wrap_zero", prog_ctr, 0);
      check_eq("wrap_no_done", done_seen, 0);
      check_eq("wrap_valid", instr_valid, 1);

      // ---------------- reset mid-RUN ----------------
      repeat (12) tick();
      check_eq("mr_at12", prog_ctr, 12);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("mr_pc", prog_ctr, 0);
      check_eq("mr_done", done, 0);
      check_eq("mr_valid", instr_valid, 0);
      repeat (3) tick();
      check_eq("mr_idle_pc", prog_ctr, 0);
      check_eq("mr_idle_valid", instr_valid, 0);
      pulse_start();
      check_eq("mr_run_pc0", prog_ctr, 0);
      check_eq("mr_run_valid", instr_valid, 1);
      tick();
      check_eq("mr_run_pc1", prog_ctr, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
